// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - opcodes, instruction classes and default memory depth for the mips32 core
// Purpose: shared decode constants and the opcode -> instruction-class mapping.
// Macro: MIPS32_MUL_EN - when defined, opcode 000101 decodes as a register-register multiply;
//        otherwise it decodes as a NOP.
package mips32_pkg;

    localparam int DEF_MEM_DEPTH = 1024;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Unassigned opcode 111110: the encoding used for pipeline bubbles.
    localparam logic [31:0] NOP_IR = 32'hF800_0000;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} iclass_t;

    function automatic iclass_t op_class(input logic [5:0] op);
        iclass_t c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: c = RR_ALU;
`ifdef MIPS32_MUL_EN
            OP_MUL:                                c = RR_ALU;
`endif
            OP_ADDI, OP_SUBI, OP_SLTI:             c = RM_ALU;
            OP_LW:                                 c = LOAD;
            OP_SW:                                 c = STORE;
            OP_BNEQZ, OP_BEQZ:                     c = BRANCH;
            OP_HLT:                                c = HALT;
            default:                               c = NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips32_pipe5_if.sv
// rtl/mips32_pipe5_if.sv - status bus of the mips32 pipeline core
// Purpose: groups the core's observable status outputs.
// Signals: halted - HLT has retired (sticky until reset); pc_o - current fetch PC (word address).
// Modports: master - driven by the core; slave - observer.
interface mips32_pipe5_if;
    logic        halted;
    logic [31:0] pc_o;

    modport master (output halted, output pc_o);
    modport slave  (input halted, input pc_o);
endinterface

// File: rtl/mips32_alu.sv
// rtl/mips32_alu.sv - combinational ALU of the mips32 core
// Purpose: computes the EX-stage result from instruction class and opcode.
// Ports: cls - instruction class; op - opcode; a, b - operands (b is rt or the immediate); y - result.
// Macro: MIPS32_MUL_EN - when defined, a multiplier for opcode 000101 is built.
module mips32_alu
    import mips32_pkg::*;
(
    input  iclass_t     cls,
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        if (cls inside {RR_ALU, RM_ALU, LOAD, STORE}) begin
            case (op)
                OP_SUB, OP_SUBI: y = a - b;
                OP_AND:          y = a & b;
                OP_OR:           y = a | b;
                OP_SLT, OP_SLTI: y = {31'd0, $signed(a) < $signed(b)};
`ifdef MIPS32_MUL_EN
                // The low 32 bits of a product are the same signed or unsigned.
                OP_MUL:          y = a * b;
`endif
                // ADD, ADDI and load/store address generation
                default:         y = a + b;
            endcase
        end
    end

endmodule

// File: rtl/mips32_pipe5.sv
// rtl/mips32_pipe5.sv - 5-stage in-order MIPS32-subset core with unified memory
// Purpose: IF/ID/EX/MEM/WB pipeline with forwarding, load-use stall, EX-resolved branches and HLT.
// Ports: clk - clock; rst_n - async active-low reset; bus.halted - HLT retired; bus.pc_o - fetch PC.
// Storage: mem[0:MEM_DEPTH-1] and Reg[0:31] are not reset so that a preload survives reset.
// Macro: MIPS32_MUL_EN - enables the MUL instruction (see mips32_pkg / mips32_alu).
module mips32_pipe5
    import mips32_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic           clk,
    input  logic           rst_n,
    mips32_pipe5_if.master bus
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] mem [0:MEM_DEPTH-1];
    logic [31:0] Reg [0:31];

    logic [31:0] pc;
    logic        halted, taken_branch, fetch_stop;

    logic [31:0] ifid_ir, ifid_npc;

    iclass_t     idex_cls;
    logic [5:0]  idex_op;
    logic [4:0]  idex_rs, idex_rt, idex_dst;
    logic        idex_wen;
    logic [31:0] idex_a, idex_b, idex_imm, idex_npc;

    iclass_t     exmem_cls;
    logic [4:0]  exmem_dst;
    logic        exmem_wen;
    logic [31:0] exmem_alu, exmem_b;

    iclass_t     memwb_cls;
    logic [4:0]  memwb_dst;
    logic        memwb_wen;
    logic [31:0] memwb_val;

    function automatic logic [AW-1:0] widx(input logic [31:0] addr);
        return AW'(addr % MEM_DEPTH);
    endfunction

    // ID: decode and register read with write-through from WB
    logic [4:0]  id_rs, id_rt, id_rd, id_dst;
    iclass_t     id_cls;
    logic [31:0] id_imm, id_a, id_b;
    logic        id_wen, load_use;

    assign id_rs  = ifid_ir[25:21];
    assign id_rt  = ifid_ir[20:16];
    assign id_rd  = ifid_ir[15:11];
    assign id_cls = op_class(ifid_ir[31:26]);
    assign id_imm = {{16{ifid_ir[15]}}, ifid_ir[15:0]};
    assign id_dst = (id_cls == RR_ALU) ? id_rd : id_rt;
    // wen is only ever set for a non-zero destination, so R0 never forwards or gets written.
    assign id_wen = (id_cls inside {RR_ALU, RM_ALU, LOAD}) && (id_dst != 5'd0);

    always_comb begin
        id_a = Reg[id_rs];
        id_b = Reg[id_rt];
        if (memwb_wen && memwb_dst == id_rs) id_a = memwb_val;
        if (memwb_wen && memwb_dst == id_rt) id_b = memwb_val;
        if (id_rs == 5'd0) id_a = '0;
        if (id_rt == 5'd0) id_b = '0;
    end

    assign load_use = (idex_cls == LOAD) && idex_wen &&
                      (((id_cls inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH}) && idex_dst == id_rs) ||
                       ((id_cls inside {RR_ALU, STORE}) && idex_dst == id_rt));

    // EX: forwarding, ALU, branch resolution
    logic [31:0] ex_a, ex_b, ex_opb, ex_y;
    logic        ex_taken;

    always_comb begin
        ex_a = idex_a;
        ex_b = idex_b;
        // A load in EX/MEM has no value yet; the load-use stall keeps consumers out of EX then.
        if (memwb_wen && memwb_dst == idex_rs) ex_a = memwb_val;
        if (memwb_wen && memwb_dst == idex_rt) ex_b = memwb_val;
        if (exmem_wen && exmem_cls != LOAD && exmem_dst == idex_rs) ex_a = exmem_alu;
        if (exmem_wen && exmem_cls != LOAD && exmem_dst == idex_rt) ex_b = exmem_alu;
    end

    assign ex_opb   = (idex_cls == RR_ALU) ? ex_b : idex_imm;
    assign ex_taken = (idex_cls == BRANCH) && ((idex_op == OP_BEQZ) == (ex_a == 32'd0));

    mips32_alu u_alu (
        .cls (idex_cls),
        .op  (idex_op),
        .a   (ex_a),
        .b   (ex_opb),
        .y   (ex_y)
    );

    // MEM: combinational data read
    logic [31:0] mem_val;
    assign mem_val = (exmem_cls == LOAD) ? mem[widx(exmem_alu)] : exmem_alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= '0;
            halted       <= 1'b0;
            taken_branch <= 1'b0;
            fetch_stop   <= 1'b0;
            ifid_ir      <= NOP_IR;
            ifid_npc     <= '0;
            idex_cls     <= NOP;
            idex_op      <= '0;
            idex_rs      <= '0;
            idex_rt      <= '0;
            idex_dst     <= '0;
            idex_wen     <= 1'b0;
            idex_a       <= '0;
            idex_b       <= '0;
            idex_imm     <= '0;
            idex_npc     <= '0;
            exmem_cls    <= NOP;
            exmem_dst    <= '0;
            exmem_wen    <= 1'b0;
            exmem_alu    <= '0;
            exmem_b      <= '0;
            memwb_cls    <= NOP;
            memwb_dst    <= '0;
            memwb_wen    <= 1'b0;
            memwb_val    <= '0;
        end else begin
            taken_branch <= ex_taken;
            if (memwb_cls == HALT) halted <= 1'b1;
            // A HLT flushed by a taken branch in EX must not stop fetch.
            if (id_cls == HALT && !ex_taken) fetch_stop <= 1'b1;

            // IF -> IF/ID
            if (ex_taken) begin
                pc      <= idex_npc + idex_imm;
                ifid_ir <= NOP_IR;
            end else if (load_use) begin
                // hold pc and IF/ID
            end else if (fetch_stop || halted || id_cls == HALT) begin
                ifid_ir <= NOP_IR;
            end else begin
                ifid_ir  <= mem[widx(pc)];
                ifid_npc <= pc + 32'd1;
                pc       <= pc + 32'd1;
            end

            // ID -> ID/EX
            if (ex_taken || load_use) begin
                idex_cls <= NOP;
                idex_wen <= 1'b0;
            end else begin
                idex_cls <= id_cls;
                idex_op  <= ifid_ir[31:26];
                idex_rs  <= id_rs;
                idex_rt  <= id_rt;
                idex_dst <= id_dst;
                idex_wen <= id_wen;
                idex_a   <= id_a;
                idex_b   <= id_b;
                idex_imm <= id_imm;
                idex_npc <= ifid_npc;
            end

            // EX -> EX/MEM
            exmem_cls <= idex_cls;
            exmem_dst <= idex_dst;
            exmem_wen <= idex_wen;
            exmem_alu <= ex_y;
            exmem_b   <= ex_b;

            // MEM -> MEM/WB
            memwb_cls <= exmem_cls;
            memwb_dst <= exmem_dst;
            memwb_wen <= exmem_wen;
            memwb_val <= mem_val;
        end
    end

    // Architectural writes: store in MEM, register write in WB; none once halted.
    always_ff @(posedge clk) begin
        if (rst_n && !halted) begin
            if (exmem_cls == STORE) mem[widx(exmem_alu)] <= exmem_b;
            if (memwb_wen) Reg[memwb_dst] <= memwb_val;
        end
    end

    assign bus.halted = halted;
    assign bus.pc_o   = pc;

endmodule

// File: tb/tb_mips32_pipe5.sv
// tb/tb_mips32_pipe5.sv - self-checking bench for mips32_pipe5
module tb_mips32_pipe5;
    import mips32_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mips32_pipe5_if bus ();

    mips32_pipe5 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_taken = 0;

    always @(negedge clk) if (rst_n && dut.taken_branch) n_taken <= n_taken + 1;

    typedef struct {
        string       name;
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        int          chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[13];

    localparam logic [31:0] HLT_IR = 32'hFC00_0000;

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", n, got, exp);
        end
    endtask

    task automatic exp_reg(input string n, input int idx, input logic [31:0] e);
        sb.push_back('{n, 1'b0, idx, e});
    endtask

    task automatic exp_mem(input string n, input int idx, input logic [31:0] e);
        sb.push_back('{n, 1'b1, idx, e});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, e.is_mem ? dut.mem[e.idx] : dut.Reg[e.idx], e.exp);
        end
    endtask

    task automatic load_defaults();
        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) dut.mem[i] = 32'h0;
        for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
        dut.mem[120] = 32'd85;
        dut.mem[500] = 32'h55AA_0F0F;
    endtask

    task automatic run(input string n, input int budget, output int cyc);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (!bus.halted && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (!bus.halted) begin
            fails++;
            $display("FAIL %s halt: halted=0 after %0d cycles, required 1", n, cyc);
        end
    endtask

    task automatic load_prog1(input bit dummies);
        int p;
        p = 0;
        dut.mem[p] = ri(OP_ADDI, 1, 0, 120); p++;
        if (dummies) begin dut.mem[p] = rr(OP_OR, 3, 3, 3); p++; end
        dut.mem[p] = ri(OP_LW, 2, 1, 0); p++;
        if (dummies) begin dut.mem[p] = rr(OP_OR, 3, 3, 3); p++; end
        dut.mem[p] = ri(OP_ADDI, 2, 2, 45); p++;
        if (dummies) begin dut.mem[p] = rr(OP_OR, 3, 3, 3); p++; end
        dut.mem[p] = ri(OP_SW, 2, 1, 1); p++;
        dut.mem[p] = HLT_IR;
    endtask

    task automatic exp_prog1();
        exp_mem("prog mem121", 121, 32'd130);
        exp_reg("prog R1", 1, 32'd120);
        exp_reg("prog R2", 2, 32'd130);
        exp_reg("prog R3", 3, 32'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int t0;

        vt[0]  = '{"add",        rr(OP_ADD, 3, 1, 2),     32'd5,         32'd7,         3, 32'd12};
        vt[1]  = '{"add wrap",   rr(OP_ADD, 3, 1, 2),     32'hFFFF_FFFF, 32'd1,         3, 32'd0};
        vt[2]  = '{"sub neg",    rr(OP_SUB, 3, 1, 2),     32'd3,         32'd5,         3, 32'hFFFF_FFFE};
        vt[3]  = '{"and",        rr(OP_AND, 3, 1, 2),     32'hF0F0,      32'hFF00,      3, 32'hF000};
        vt[4]  = '{"or",         rr(OP_OR, 3, 1, 2),      32'hF0F0,      32'hFF00,      3, 32'hFFF0};
        vt[5]  = '{"slt signed", rr(OP_SLT, 3, 1, 2),     32'hFFFF_FFFF, 32'd1,         3, 32'd1};
        vt[6]  = '{"slt false",  rr(OP_SLT, 3, 1, 2),     32'd1,         32'hFFFF_FFFF, 3, 32'd0};
        vt[7]  = '{"addi neg",   ri(OP_ADDI, 3, 1, -1),   32'd0,         32'd0,         3, 32'hFFFF_FFFF};
        vt[8]  = '{"subi",       ri(OP_SUBI, 3, 1, 3),    32'd10,        32'd0,         3, 32'd7};
        vt[9]  = '{"slti",       ri(OP_SLTI, 3, 1, -4),   32'hFFFF_FFFB, 32'd0,         3, 32'd1};
        vt[10] = '{"slti equal", ri(OP_SLTI, 3, 1, 5),    32'd5,         32'd0,         3, 32'd0};
        vt[11] = '{"nop opcode", rr(6'b010000, 3, 1, 2),  32'd9,         32'd9,         3, 32'd3};
        vt[12] = '{"r0 write",   ri(OP_ADDI, 0, 1, 5),    32'd10,        32'd0,         0, 32'd0};

        // reset state
        load_defaults();
        @(negedge clk);
        check("reset pc", bus.pc_o, 32'd0);
        check("reset halted", {31'd0, bus.halted}, 32'd0);
        check("reset taken_branch", {31'd0, dut.taken_branch}, 32'd0);

        // single-instruction ALU vectors
        for (int i = 0; i < 13; i++) begin
            load_defaults();
            dut.Reg[1] = vt[i].a;
            dut.Reg[2] = vt[i].b;
            dut.mem[0] = vt[i].instr;
            dut.mem[1] = HLT_IR;
            exp_reg(vt[i].name, vt[i].chk, vt[i].exp);
            run(vt[i].name, 30, cyc);
            drain();
        end

        // HLT alone: five cycles from fetch to retirement
        load_defaults();
        dut.mem[0] = HLT_IR;
        run("hlt only", 30, cyc);
        check("hlt latency", 32'(cyc), 32'd5);

        // reference program with dummy ORs
        load_defaults();
        load_prog1(1'b1);
        exp_prog1();
        run("prog1", 20, cyc);
        drain();
        repeat (3) @(negedge clk);
        check("prog1 pc frozen", bus.pc_o, 32'd8);

        // same program relying on forwarding and one load-use stall
        load_defaults();
        load_prog1(1'b0);
        exp_prog1();
        run("prog2", 20, cyc);
        drain();
        check("prog2 cycles", 32'(cyc), 32'd10);

        // taken BEQZ skips two writes; HLT at the target
        load_defaults();
        dut.Reg[1] = 32'd0;
        dut.mem[0] = ri(OP_BEQZ, 0, 1, 2);
        dut.mem[1] = ri(OP_ADDI, 5, 0, 99);
        dut.mem[2] = ri(OP_ADDI, 5, 0, 77);
        dut.mem[3] = HLT_IR;
        exp_reg("beqz R5", 5, 32'd5);
        t0 = n_taken;
        run("beqz", 30, cyc);
        drain();
        check("beqz taken pulses", 32'(n_taken - t0), 32'd1);

        // BNEQZ on R0 falls through
        load_defaults();
        dut.mem[0] = ri(OP_BNEQZ, 0, 0, 3);
        dut.mem[1] = ri(OP_ADDI, 6, 0, 66);
        dut.mem[2] = HLT_IR;
        exp_reg("bneqz R6", 6, 32'd66);
        t0 = n_taken;
        run("bneqz", 30, cyc);
        drain();
        check("bneqz taken pulses", 32'(n_taken - t0), 32'd0);

        // MUL
        load_defaults();
        dut.Reg[2] = 32'd7;
        dut.Reg[3] = 32'hFFFF_FFFD;
        dut.mem[0] = rr(OP_MUL, 4, 2, 3);
        dut.mem[1] = HLT_IR;
`ifdef MIPS32_MUL_EN
        exp_reg("mul R4", 4, 32'hFFFF_FFEB);
`else
        exp_reg("mul R4", 4, 32'd4);
`endif
        run("mul", 30, cyc);
        drain();

        // reset pulse mid-run restarts from mem[0]
        load_defaults();
        load_prog1(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst pc", bus.pc_o, 32'd0);
        check("midrst halted", {31'd0, bus.halted}, 32'd0);
        exp_prog1();
        exp_mem("midrst mem500", 500, 32'h55AA_0F0F);
        exp_reg("midrst R10", 10, 32'd10);
        run("midrst", 30, cyc);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
